pcs_40g_rx_am_lock: RTL and testbench

Per-lane alignment-marker (AM) lock for the 40GBASE-R receive PCS. It is the receive counterpart of AM insertion in pcs_40g_tx.
- Sits after block sync on each PCS lane: one instance per lane, four in total.
- Finds and tracks the periodic AM, identifies which logical PCS lane the physical lane carries, and flags AM blocks so the downstream deskew/reorder logic can align lanes and strip markers.
- Implements the am_lock state machine of IEEE 802.3 clause 82.

---
 rtl/pcs_pkg.sv | 27 ++
 rtl/pcs_40g_rx_am_lock_if.sv | 36 +++
 rtl/pcs_40g_am_match.sv | 44 ++++
 rtl/pcs_40g_rx_am_lock.sv | 157 +++++++++++++++
 tb/tb_pcs_40g_rx_am_lock.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pcs_pkg.sv
// Shared constants and types for the 40GBASE-R receive PCS.
// Holds the alignment-marker byte patterns of the four logical PCS lanes,
// the sync header codes, and the state type of the am_lock state machine.
package pcs_pkg;

   // Sync header codes of 64b/66b blocks.
   localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;
   localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;

   localparam int AM_LANES = 4;

   // Marker bytes per logical lane: AM_LANE[lane][i] is Mi.
   // The concatenation is listed from lane 3 down to lane 0, and M2 down to M0.
   localparam logic [3:0][2:0][7:0] AM_LANE = {
      {8'h3D, 8'h79, 8'hA2},
      {8'h9B, 8'h65, 8'hC5},
      {8'hE6, 8'hC4, 8'hF0},
      {8'h47, 8'h76, 8'h90}
   };

   typedef enum logic [1:0] {
      FIND_1ST  = 2'd0,
      COUNT_2ND = 2'd1,
      LOCK      = 2'd2
   } am_lock_state_t;

endpackage

// File: rtl/pcs_40g_rx_am_lock_if.sv
// Block stream bundle of one receive PCS lane around the AM lock stage.
//   block_lock_i        block sync lock of the lane
//   valid_i/head_i/data_i  incoming 66-bit block with valid qualifier
//   valid_o/head_o/data_o  the same block one cycle later
//   am_v_o              marks the output block that is the tracked AM
//   am_lock_o           alignment marker lock
//   lane_o              logical PCS lane carried by this physical lane
// master drives the incoming block and observes the results; slave is the
// AM lock stage itself.
interface pcs_40g_rx_am_lock_if #(
   parameter int DATA_W = 64,
   parameter int HEAD_W = 2
) ();

   logic              block_lock_i;
   logic              valid_i;
   logic [HEAD_W-1:0] head_i;
   logic [DATA_W-1:0] data_i;
   logic              valid_o;
   logic [HEAD_W-1:0] head_o;
   logic [DATA_W-1:0] data_o;
   logic              am_v_o;
   logic              am_lock_o;
   logic [1:0]        lane_o;

   modport master (
      output block_lock_i, valid_i, head_i, data_i,
      input  valid_o, head_o, data_o, am_v_o, am_lock_o, lane_o
   );

   modport slave (
      input  block_lock_i, valid_i, head_i, data_i,
      output valid_o, head_o, data_o, am_v_o, am_lock_o, lane_o
   );

endinterface

// File: rtl/pcs_40g_am_match.sv
// Combinational alignment-marker detector.
// Compares one 66-bit block against the marker patterns of all four logical
// lanes. A block is a marker when it carries a control header, bytes 0..2
// equal M0..M2 and bytes 4..6 equal their bitwise complement. The BIP bytes
// 3 and 7 are not examined.
//   head        sync header of the block
//   data        block payload, byte 0 in data[7:0]
//   match       block is a marker of some lane
//   match_lane  the lane whose marker was recognised (0 when no match)
module pcs_40g_am_match
   import pcs_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int HEAD_W = 2
) (
   input  logic [HEAD_W-1:0] head,
   input  logic [DATA_W-1:0] data,
   output logic              match,
   output logic [1:0]        match_lane
);

   logic unused_bip;
   assign unused_bip = ^{data[31:24], data[63:56]};

   // The four marker patterns are mutually distinct, so at most one lane can
   // hit; the loop simply reports whichever one does.
   always_comb begin
      match      = 1'b0;
      match_lane = 2'd0;
      for (int k = 0; k < AM_LANES; k++) begin
         if (head == SYNC_HEAD_CTRL &&
             data[7:0]   ==  AM_LANE[k][0] &&
             data[15:8]  ==  AM_LANE[k][1] &&
             data[23:16] ==  AM_LANE[k][2] &&
             data[39:32] == ~AM_LANE[k][0] &&
             data[47:40] == ~AM_LANE[k][1] &&
             data[55:48] == ~AM_LANE[k][2]) begin
            match      = 1'b1;
            match_lane = 2'(k);
         end
      end
   end

endmodule

// File: rtl/pcs_40g_rx_am_lock.sv
// Per-lane alignment-marker lock for the 40GBASE-R receive PCS.
// Finds the periodic AM on one physical lane, confirms it with a second AM
// one period later, then keeps checking it every period. While locked it
// reports which logical lane the physical lane carries and flags each AM
// block on the output so deskew can align lanes and strip markers.
//   clk, nreset   clock and asynchronous active-low reset
//   am_bus        slave side of the lane block stream (see the interface)
// The block stream is delayed by one register stage; am_v_o, am_lock_o and
// lane_o are aligned to that delayed block.
module pcs_40g_rx_am_lock
   import pcs_pkg::*;
#(
   parameter int DATA_W       = 64,
   parameter int HEAD_W       = 2,
   parameter int AM_PERIOD    = 16384,
   parameter int AM_INVLD_MAX = 4,
   parameter int CNT_W        = $clog2(AM_PERIOD)
) (
   input logic                 clk,
   input logic                 nreset,
   pcs_40g_rx_am_lock_if.slave am_bus
);

   localparam int INV_W = $clog2(AM_INVLD_MAX + 1);

   am_lock_state_t    state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [INV_W-1:0]  invld_cnt, invld_cnt_n;
   logic [1:0]        lane, lane_n;
   logic              am_v_n;

   logic              raw_match, match, check_pt, same_lane;
   logic [1:0]        match_lane;

   logic              valid_q, am_v_q, am_lock_q;
   logic [HEAD_W-1:0] head_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        lane_q;

   pcs_40g_am_match #(
      .DATA_W (DATA_W),
      .HEAD_W (HEAD_W)
   ) u_match (
      .head       (am_bus.head_i),
      .data       (am_bus.data_i),
      .match      (raw_match),
      .match_lane (match_lane)
   );

   // A marker only counts on a valid block. cnt holds the number of valid
   // blocks seen since the last accepted AM, minus one, so the block that
   // arrives while cnt sits at AM_PERIOD-1 is exactly one period after it.
   assign match     = am_bus.valid_i & raw_match;
   assign check_pt  = (cnt == CNT_W'(AM_PERIOD - 1));
   assign same_lane = match && (match_lane == lane);

   // State, counters and stored lane.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= FIND_1ST;
         cnt       <= '0;
         invld_cnt <= '0;
         lane      <= 2'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         invld_cnt <= invld_cnt_n;
         lane      <= lane_n;
      end
   end

   // Next-state logic. Loss of block lock overrides everything; otherwise
   // only valid blocks move the machine. The position counter wraps at every
   // check point whether or not the marker there was good, which keeps the
   // check phase fixed while a few markers are corrupted.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      invld_cnt_n = invld_cnt;
      lane_n      = lane;
      am_v_n      = 1'b0;

      if (!am_bus.block_lock_i) begin
         state_n     = FIND_1ST;
         cnt_n       = '0;
         invld_cnt_n = '0;
      end else if (am_bus.valid_i) begin
         cnt_n = check_pt ? '0 : cnt + CNT_W'(1);
         case (state)
            FIND_1ST: begin
               if (match) begin
                  lane_n  = match_lane;
                  cnt_n   = '0;
                  state_n = COUNT_2ND;
               end
            end
            COUNT_2ND: begin
               if (check_pt) begin
                  if (same_lane) begin
                     state_n     = LOCK;
                     invld_cnt_n = '0;
                     am_v_n      = 1'b1;
                  end else begin
                     state_n = FIND_1ST;
                  end
               end
            end
            LOCK: begin
               if (check_pt) begin
                  if (same_lane) begin
                     am_v_n      = 1'b1;
                     invld_cnt_n = '0;
                  end else if (invld_cnt == INV_W'(AM_INVLD_MAX - 1)) begin
                     state_n     = FIND_1ST;
                     invld_cnt_n = '0;
                     cnt_n       = '0;
                  end else begin
                     invld_cnt_n = invld_cnt + INV_W'(1);
                  end
               end
            end
            default: begin
               state_n = FIND_1ST;
            end
         endcase
      end
   end

   // Output stage: one-cycle copy of the block plus status derived from the
   // state the block leads into, so lock rises on the confirming AM and falls
   // on the block that loses it.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q   <= 1'b0;
         head_q    <= '0;
         data_q    <= '0;
         am_v_q    <= 1'b0;
         am_lock_q <= 1'b0;
         lane_q    <= 2'd0;
      end else begin
         valid_q   <= am_bus.valid_i;
         head_q    <= am_bus.head_i;
         data_q    <= am_bus.data_i;
         am_v_q    <= am_v_n;
         am_lock_q <= (state_n == LOCK);
         lane_q    <= (state_n == LOCK) ? lane_n : 2'd0;
      end
   end

   assign am_bus.valid_o   = valid_q;
   assign am_bus.head_o    = head_q;
   assign am_bus.data_o    = data_q;
   assign am_bus.am_v_o    = am_v_q;
   assign am_bus.am_lock_o = am_lock_q;
   assign am_bus.lane_o    = lane_q;

endmodule

// File: tb/tb_pcs_40g_rx_am_lock.sv
// Self-checking bench for pcs_40g_rx_am_lock with a 16-block AM period.
// Each driven block pushes its expected output onto a scoreboard queue; the
// entry is popped and compared when the registered output appears.
module tb_pcs_40g_rx_am_lock;

   localparam int PERIOD = 16;

   typedef struct {
      logic        valid;
      logic [1:0]  head;
      logic [63:0] data;
      logic        am_v;
      logic        lock;
      logic [1:0]  lane;
   } exp_t;

   logic clk;
   logic nreset;
   int   total;
   int   bad;
   int   cyc;
   exp_t sb[$];

   pcs_40g_rx_am_lock_if #(.DATA_W(64), .HEAD_W(2)) am_bus ();

   pcs_40g_rx_am_lock #(
      .DATA_W       (64),
      .HEAD_W       (2),
      .AM_PERIOD    (PERIOD),
      .AM_INVLD_MAX (4)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .am_bus (am_bus)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence below ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Builds a marker block from the bench's own lane table. corrupt=1 breaks
   // an inverted byte, corrupt=3 breaks byte 0; BIP bytes are random.
   function automatic logic [63:0] amData(input int lane, input int corrupt);
      logic [23:0] m;
      logic [7:0]  b0, b1, b2;
      logic [63:0] d;
      case (lane)
         0:       m = 24'h907647;
         1:       m = 24'hF0C4E6;
         2:       m = 24'hC5659B;
         default: m = 24'hA2793D;
      endcase
      b0 = m[23:16];
      b1 = m[15:8];
      b2 = m[7:0];
      d = {8'($urandom), ~b2, ~b1, ~b0, 8'($urandom), b2, b1, b0};
      if (corrupt == 1) d[40] = ~d[40];
      if (corrupt == 3) d[0]  = ~d[0];
      return d;
   endfunction

   // Drives one cycle, records the expectation, then compares one cycle later.
   task automatic applyStimulus(input logic v, input logic [1:0] h, input logic [63:0] d,
                                input logic eamv, input logic elock, input logic [1:0] elane);
      exp_t e;
      am_bus.valid_i = v;
      am_bus.head_i  = h;
      am_bus.data_i  = d;
      e.valid = v;
      e.head  = h;
      e.data  = d;
      e.am_v  = eamv;
      e.lock  = elock;
      e.lane  = elane;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
         checkOutput("scoreboard_empty", 64'd0, 64'd1);
      end else begin
         e = sb.pop_front();
         checkOutput($sformatf("valid_o@%0d", cyc),   64'(am_bus.valid_o),   64'(e.valid));
         checkOutput($sformatf("head_o@%0d", cyc),    64'(am_bus.head_o),    64'(e.head));
         checkOutput($sformatf("data_o@%0d", cyc),    am_bus.data_o,         e.data);
         checkOutput($sformatf("am_v_o@%0d", cyc),    64'(am_bus.am_v_o),    64'(e.am_v));
         checkOutput($sformatf("am_lock_o@%0d", cyc), 64'(am_bus.am_lock_o), 64'(e.lock));
         checkOutput($sformatf("lane_o@%0d", cyc),    64'(am_bus.lane_o),    64'(e.lane));
      end
   endtask

   // corrupt=2 replaces the control header with a data header.
   task automatic sendAm(input int lane, input int corrupt,
                         input logic eamv, input logic elock, input logic [1:0] elane);
      applyStimulus(1'b1, (corrupt == 2) ? 2'b01 : 2'b10, amData(lane, corrupt), eamv, elock, elane);
   endtask

   task automatic sendData(input int n, input logic elock, input logic [1:0] elane);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b1, 2'b01, {$urandom, $urandom}, 1'b0, elock, elane);
   endtask

   // Idle cycles carry a perfect marker pattern that must be ignored.
   task automatic sendGap(input int n, input logic elock, input logic [1:0] elane);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 2'b10, amData(2, 0), 1'b0, elock, elane);
   endtask

   task automatic dropBlockLock();
      am_bus.block_lock_i = 1'b0;
      sendData(1, 1'b0, 2'd0);
      am_bus.block_lock_i = 1'b1;
   endtask

   // Main sequence.
   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      nreset = 1'b0;
      am_bus.block_lock_i = 1'b0;
      am_bus.valid_i = 1'b0;
      am_bus.head_i  = 2'b00;
      am_bus.data_i  = 64'd0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid_o",   64'(am_bus.valid_o),   64'd0);
      checkOutput("reset_data_o",    am_bus.data_o,         64'd0);
      checkOutput("reset_am_v_o",    64'(am_bus.am_v_o),    64'd0);
      checkOutput("reset_am_lock_o", 64'(am_bus.am_lock_o), 64'd0);
      checkOutput("reset_lane_o",    64'(am_bus.lane_o),    64'd0);
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      am_bus.block_lock_i = 1'b1;

      $display("[TB] lane 2 acquisition");
      sendAm(2, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(2, 0, 1'b1, 1'b1, 2'd2);
      sendData(PERIOD - 1, 1'b1, 2'd2);
      sendAm(2, 0, 1'b1, 1'b1, 2'd2);

      $display("[TB] stalls and off-phase marker while locked");
      sendData(7, 1'b1, 2'd2);
      sendGap(5, 1'b1, 2'd2);
      sendData(8, 1'b1, 2'd2);
      sendAm(2, 0, 1'b1, 1'b1, 2'd2);
      sendData(4, 1'b1, 2'd2);
      sendAm(2, 0, 1'b0, 1'b1, 2'd2);
      sendData(PERIOD - 6, 1'b1, 2'd2);
      sendAm(2, 0, 1'b1, 1'b1, 2'd2);

      $display("[TB] block lock loss and re-lock");
      dropBlockLock();
      sendAm(2, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(2, 0, 1'b1, 1'b1, 2'd2);

      $display("[TB] lane mismatch between first and second marker");
      dropBlockLock();
      sendAm(0, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(1, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(1, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(1, 0, 1'b1, 1'b1, 2'd1);

      $display("[TB] corrupted markers on lane 3");
      dropBlockLock();
      sendAm(3, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(3, 0, 1'b1, 1'b1, 2'd3);
      for (int i = 1; i <= 3; i++) begin
         sendData(PERIOD - 1, 1'b1, 2'd3);
         sendAm(3, i, 1'b0, 1'b1, 2'd3);
      end
      sendData(PERIOD - 1, 1'b1, 2'd3);
      sendAm(3, 0, 1'b1, 1'b1, 2'd3);
      for (int i = 1; i <= 3; i++) begin
         sendData(PERIOD - 1, 1'b1, 2'd3);
         sendAm(3, i, 1'b0, 1'b1, 2'd3);
      end
      sendData(PERIOD - 1, 1'b1, 2'd3);
      sendAm(3, 1, 1'b0, 1'b0, 2'd0);
      sendData(3, 1'b0, 2'd0);

      $display("[TB] reset during second-marker count");
      sendAm(1, 0, 1'b0, 1'b0, 2'd0);
      sendData(5, 1'b0, 2'd0);
      nreset = 1'b0;
      #1;
      checkOutput("midreset_valid_o",   64'(am_bus.valid_o),   64'd0);
      checkOutput("midreset_head_o",    64'(am_bus.head_o),    64'd0);
      checkOutput("midreset_data_o",    am_bus.data_o,         64'd0);
      checkOutput("midreset_am_lock_o", 64'(am_bus.am_lock_o), 64'd0);
      am_bus.valid_i = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      @(posedge clk);
      #1;
      sendData(PERIOD - 6, 1'b0, 2'd0);
      sendAm(1, 0, 1'b0, 1'b0, 2'd0);
      sendData(PERIOD - 1, 1'b0, 2'd0);
      sendAm(1, 0, 1'b1, 1'b1, 2'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
